// File: rtl/nxm_status_if.sv
// NXM status bus bundle: bus-monitor pulse, CPU address, CSR write port,
// microcode page-fail handshake and status/count readback.
interface nxm_status_if #(
  parameter int CNTW = 8
);
  logic            nxmINTR;
  logic [0:35]     cpuADDRO;
  logic            csrWRITE;
  logic [0:35]     csrDATA;
  logic            nxmPFACK;
  logic            nxmPFREQ;
  logic [0:35]     nxmSTATUS;
  logic [0:CNTW-1] nxmCOUNT;

  modport master (
    output nxmINTR,
    output cpuADDRO,
    output csrWRITE,
    output csrDATA,
    output nxmPFACK,
    input  nxmPFREQ,
    input  nxmSTATUS,
    input  nxmCOUNT
  );

  modport slave (
    input  nxmINTR,
    input  cpuADDRO,
    input  csrWRITE,
    input  csrDATA,
    input  nxmPFACK,
    output nxmPFREQ,
    output nxmSTATUS,
    output nxmCOUNT
  );
endinterface

// File: rtl/nxm_status.sv
// NXM status: captures the first failing address, raises a page-fail
// request until acked, flags overruns and counts NXM events (saturating).
// Ports: clk, rst (sync, active-high), bus (nxm_status_if.slave):
//   in  nxmINTR, cpuADDRO, csrWRITE, csrDATA, nxmPFACK
//   out nxmPFREQ, nxmSTATUS, nxmCOUNT
module nxm_status #(
  parameter int CNTW = 8
) (
  input logic        clk,
  input logic        rst,
  nxm_status_if.slave bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_HELD = 2'd2;

  localparam logic [CNTW-1:0] CNT_MAX = '1;

  logic [1:0]      state_q, state_d;
  logic [1:0]      eff_st;
  logic            valid_q, valid_d;
  logic            ovr_q, ovr_d;
  logic            pf_q, pf_d;
  logic [21:0]     addr_q, addr_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [CNTW-1:0] cnt_base;

  logic clr_err;
  logic clr_cnt;
  logic intr;
  logic ack;

  assign intr    = bus.nxmINTR;
  assign ack     = bus.nxmPFACK;
  assign clr_err = bus.csrWRITE & bus.csrDATA[0];
  assign clr_cnt = bus.csrWRITE & bus.csrDATA[1];

  wire unused_bits = ^{bus.csrDATA[2:35], bus.cpuADDRO[0:13]};

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    addr_d  = addr_q;

    // A clear error lands first, so a same-cycle event is seen from IDLE.
    if (clr_err) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
      addr_d  = '0;
    end

    eff_st = clr_err ? S_IDLE : state_q;
    if (eff_st == 2'b11) begin
      eff_st = S_IDLE;
    end
    state_d = eff_st;

    case (eff_st)
      S_REQ: begin
        if (intr) begin
          ovr_d = 1'b1;
        end
        if (ack) begin
          state_d = S_HELD;
        end
      end
      S_HELD: begin
        if (intr) begin
          ovr_d = 1'b1;
        end
      end
      default: begin
        if (intr) begin
          addr_d  = bus.cpuADDRO[14:35];
          valid_d = 1'b1;
          ovr_d   = 1'b0;
          state_d = S_REQ;
        end
      end
    endcase

    pf_d = (state_d == S_REQ);
  end

  // Counter clear applies before the increment: clear + pulse gives 1.
  always_comb begin
    cnt_base = clr_cnt ? '0 : cnt_q;
    cnt_d    = cnt_base;
    if (intr && (cnt_base != CNT_MAX)) begin
      cnt_d = cnt_base + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
      pf_q    <= 1'b0;
      addr_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
      pf_q    <= pf_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.nxmPFREQ  = pf_q;
  assign bus.nxmSTATUS = {valid_q, ovr_q, pf_q, 11'b0, addr_q};
  assign bus.nxmCOUNT  = cnt_q;

endmodule

// File: tb/tb_nxm_status.sv
// Scoreboard bench for nxm_status: expected words are queued as stimulus
// is driven and compared one cycle later against the registered outputs.
module tb_nxm_status;

  localparam int CNTW = 8;

  typedef struct packed {
    logic        pf;
    logic [35:0] st;
    logic [7:0]  cnt;
  } exp_t;

  logic clk;
  logic rst;

  nxm_status_if #(.CNTW(CNTW)) bus ();

  nxm_status #(.CNTW(CNTW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t sb[$];
  exp_t got;
  exp_t e;
  int   vecs;
  int   errs;

  localparam logic [35:0] A1 = 36'o000000123456;
  localparam logic [35:0] A2 = 36'o000000777777;
  localparam logic [35:0] A3 = 36'o000000001000;

  function automatic exp_t mk(
    input logic pf, input logic v, input logic o, input logic p,
    input logic [35:0] a, input int c
  );
    exp_t r;
    r.pf  = pf;
    r.st  = {v, o, p, 11'b0, a[21:0]};
    r.cnt = c[7:0];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    got.pf  = bus.nxmPFREQ;
    got.st  = bus.nxmSTATUS;
    got.cnt = bus.nxmCOUNT;
  endtask

  task automatic idle_inputs();
    bus.nxmINTR  = 1'b0;
    bus.cpuADDRO = '0;
    bus.csrWRITE = 1'b0;
    bus.csrDATA  = '0;
    bus.nxmPFACK = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    sb.push_back(mk(0, 0, 0, 0, 0, 0));
    tick();
    e = sb.pop_front();
    vecs++;
    if (got !== e) begin
      errs++;
      $display("FAIL reset: got %h want %h", got, e);
    end
  endtask

  task automatic test_capture_ack();
    bus.nxmINTR  = 1'b1;
    bus.cpuADDRO = A1;
    sb.push_back(mk(1, 1, 0, 1, A1, 1));
    tick();
    bus.nxmINTR  = 1'b0;
    bus.cpuADDRO = 36'o777777777777;
    e = sb.pop_front();
    vecs++;
    if (got !== e) begin
      errs++;
      $display("FAIL capture: got %h want %h", got, e);
    end
    for (int i = 0; i < 2; i++) begin
      sb.push_back(mk(1, 1, 0, 1, A1, 1));
      tick();
      e = sb.pop_front();
      vecs++;
      if (got !== e) begin
        errs++;
        $display("FAIL req_hold%0d: got %h want %h", i, got, e);
      end
    end
    bus.nxmPFACK = 1'b1;
    for (int i = 0; i < 2; i++) begin
      sb.push_back(mk(0, 1, 0, 0, A1, 1));
      tick();
      e = sb.pop_front();
      vecs++;
      if (got !== e) begin
        errs++;
        $display("FAIL ack%0d: got %h want %h", i, got, e);
      end
    end
    bus.nxmPFACK = 1'b0;
  endtask

  task automatic test_overrun();
    bus.nxmINTR  = 1'b1;
    bus.cpuADDRO = A2;
    sb.push_back(mk(0, 1, 1, 0, A1, 2));
    tick();
    bus.nxmINTR = 1'b0;
    e = sb.pop_front();
    vecs++;
    if (got !== e) begin
      errs++;
      $display("FAIL overrun: got %h want %h", got, e);
    end
  endtask

  task automatic test_saturation();
    int c;
    c = 2;
    bus.nxmINTR  = 1'b1;
    bus.cpuADDRO = A2;
    for (int i = 0; i < 300; i++) begin
      c = (c < 255) ? c + 1 : 255;
      sb.push_back(mk(0, 1, 1, 0, A1, c));
      tick();
      e = sb.pop_front();
      vecs++;
      if (got !== e) begin
        errs++;
        $display("FAIL sat%0d: got %h want %h", i, got, e);
      end
    end
    bus.nxmINTR  = 1'b0;
    bus.csrWRITE = 1'b1;
    bus.csrDATA  = 36'o200000000000;
    sb.push_back(mk(0, 1, 1, 0, A1, 0));
    tick();
    e = sb.pop_front();
    vecs++;
    if (got !== e) begin
      errs++;
      $display("FAIL cnt_clear: got %h want %h", got, e);
    end
    bus.nxmINTR = 1'b1;
    sb.push_back(mk(0, 1, 1, 0, A1, 1));
    tick();
    e = sb.pop_front();
    vecs++;
    if (got !== e) begin
      errs++;
      $display("FAIL cnt_clear_intr: got %h want %h", got, e);
    end
    bus.nxmINTR = 1'b0;
    bus.csrDATA = 36'o000000000000;
    sb.push_back(mk(0, 1, 1, 0, A1, 1));
    tick();
    bus.csrWRITE = 1'b0;
    e = sb.pop_front();
    vecs++;
    if (got !== e) begin
      errs++;
      $display("FAIL csr_noop: got %h want %h", got, e);
    end
  endtask

  task automatic test_clear_and_new();
    bus.csrWRITE = 1'b1;
    bus.csrDATA  = 36'o400000000000;
    bus.nxmINTR  = 1'b1;
    bus.cpuADDRO = A3;
    sb.push_back(mk(1, 1, 0, 1, A3, 2));
    tick();
    idle_inputs();
    e = sb.pop_front();
    vecs++;
    if (got !== e) begin
      errs++;
      $display("FAIL clear_new: got %h want %h", got, e);
    end
    sb.push_back(mk(1, 1, 0, 1, A3, 2));
    tick();
    e = sb.pop_front();
    vecs++;
    if (got !== e) begin
      errs++;
      $display("FAIL clear_new_hold: got %h want %h", got, e);
    end
  endtask

  task automatic test_clear_during_req();
    bus.csrWRITE = 1'b1;
    bus.csrDATA  = 36'o400000000000;
    bus.nxmPFACK = 1'b1;
    sb.push_back(mk(0, 0, 0, 0, 0, 2));
    tick();
    bus.csrWRITE = 1'b0;
    bus.csrDATA  = '0;
    e = sb.pop_front();
    vecs++;
    if (got !== e) begin
      errs++;
      $display("FAIL clear_req: got %h want %h", got, e);
    end
    sb.push_back(mk(0, 0, 0, 0, 0, 2));
    tick();
    bus.nxmPFACK = 1'b0;
    e = sb.pop_front();
    vecs++;
    if (got !== e) begin
      errs++;
      $display("FAIL late_ack: got %h want %h", got, e);
    end
  endtask

  task automatic test_back_to_back();
    bus.nxmINTR  = 1'b1;
    bus.cpuADDRO = A1;
    sb.push_back(mk(1, 1, 0, 1, A1, 3));
    tick();
    e = sb.pop_front();
    vecs++;
    if (got !== e) begin
      errs++;
      $display("FAIL b2b0: got %h want %h", got, e);
    end
    bus.cpuADDRO = A2;
    bus.nxmPFACK = 1'b1;
    sb.push_back(mk(0, 1, 1, 0, A1, 4));
    tick();
    e = sb.pop_front();
    vecs++;
    if (got !== e) begin
      errs++;
      $display("FAIL b2b_ack: got %h want %h", got, e);
    end
    bus.nxmPFACK = 1'b0;
    bus.cpuADDRO = A3;
    sb.push_back(mk(0, 1, 1, 0, A1, 5));
    tick();
    idle_inputs();
    e = sb.pop_front();
    vecs++;
    if (got !== e) begin
      errs++;
      $display("FAIL b2b2: got %h want %h", got, e);
    end
  endtask

  task automatic test_reset_mid();
    bus.csrWRITE = 1'b1;
    bus.csrDATA  = 36'o600000000000;
    sb.push_back(mk(0, 0, 0, 0, 0, 0));
    tick();
    idle_inputs();
    e = sb.pop_front();
    vecs++;
    if (got !== e) begin
      errs++;
      $display("FAIL clear_both: got %h want %h", got, e);
    end
    bus.nxmINTR  = 1'b1;
    bus.cpuADDRO = A2;
    for (int i = 1; i <= 5; i++) begin
      sb.push_back(mk(1, 1, i > 1, 1, A2, i));
      tick();
      e = sb.pop_front();
      vecs++;
      if (got !== e) begin
        errs++;
        $display("FAIL fill%0d: got %h want %h", i, got, e);
      end
    end
    rst          = 1'b1;
    bus.csrWRITE = 1'b1;
    bus.csrDATA  = 36'o000000000000;
    bus.nxmPFACK = 1'b1;
    sb.push_back(mk(0, 0, 0, 0, 0, 0));
    tick();
    rst = 1'b0;
    idle_inputs();
    e = sb.pop_front();
    vecs++;
    if (got !== e) begin
      errs++;
      $display("FAIL reset_mid: got %h want %h", got, e);
    end
    sb.push_back(mk(0, 0, 0, 0, 0, 0));
    tick();
    e = sb.pop_front();
    vecs++;
    if (got !== e) begin
      errs++;
      $display("FAIL after_reset: got %h want %h", got, e);
    end
  endtask

  initial begin
    vecs = 0;
    errs = 0;
    rst  = 1'b1;
    idle_inputs();
    test_reset();
    test_capture_ack();
    test_overrun();
    test_saturation();
    test_clear_and_new();
    test_clear_during_req();
    test_back_to_back();
    test_reset_mid();
    if (sb.size() != 0) begin
      errs++;
      $display("FAIL scoreboard: got %0d left want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
